// File: rtl/axis_slave_fifo.sv
// AXI4-Stream slave FIFO: buffers upstream beats and hands them to user logic
// through a registered pop port with registered occupancy/credit flags.
module axis_slave_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          axis_tvalid,
    output logic                          axis_tready,
    input  logic [DATA_WIDTH-1:0]         axis_tdata,
    output logic                          may_pop,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         data,
    output logic                          data_valid,
    output logic                          underflow,
    output logic [$clog2(DEPTH+1)-1:0]    count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef logic [CW-1:0] count_t;
    typedef logic [AW-1:0] ptr_t;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    ptr_t                  wr_ptr_q, wr_ptr_d;
    ptr_t                  rd_ptr_q, rd_ptr_d;
    count_t                count_q, count_d;
    logic                  tready_q, tready_d;
    logic                  may_pop_q, may_pop_d;
    logic                  data_valid_q, data_valid_d;
    logic                  underflow_q, underflow_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic accept;
    logic do_pop;

    assign accept = axis_tvalid & tready_q;
    assign do_pop = pop & may_pop_q;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        data_d       = data_q;
        data_valid_d = do_pop;
        underflow_d  = underflow_q | (pop & ~may_pop_q);

        if (accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            data_d   = mem_q[rd_ptr_q];
        end

        // Flags come from the next occupancy, so tready is already low the
        // cycle after the filling accept and the FIFO can never overflow.
        count_d   = count_q + count_t'(accept) - count_t'(do_pop);
        may_pop_d = (count_d != '0);
        tready_d  = (count_d < count_t'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            tready_q     <= 1'b0;
            may_pop_q    <= 1'b0;
            data_valid_q <= 1'b0;
            data_q       <= '0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            tready_q     <= tready_d;
            may_pop_q    <= may_pop_d;
            data_valid_q <= data_valid_d;
            data_q       <= data_d;
            underflow_q  <= underflow_d;
        end
    end

    // NOTE: storage is deliberately left out of reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            mem_q[wr_ptr_q] <= axis_tdata;
        end
    end

    assign axis_tready = tready_q;
    assign may_pop     = may_pop_q;
    assign data        = data_q;
    assign data_valid  = data_valid_q;
    assign underflow   = underflow_q;
    assign count       = count_q;

endmodule

// File: tb/tb_axis_slave_fifo.sv
// Self-checking bench for axis_slave_fifo: a reference occupancy/flag model plus
// a data scoreboard filled on accept and drained as popped data appears.
module tb_axis_slave_fifo;
    localparam int DATA_WIDTH = 32;
    localparam int DEPTH      = 16;
    localparam int CW         = $clog2(DEPTH + 1);

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  axis_tvalid = 1'b0;
    logic                  axis_tready;
    logic [DATA_WIDTH-1:0] axis_tdata = '0;
    logic                  may_pop;
    logic                  pop = 1'b0;
    logic [DATA_WIDTH-1:0] data;
    logic                  data_valid;
    logic                  underflow;
    logic [CW-1:0]         count;

    axis_slave_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .axis_tvalid (axis_tvalid),
        .axis_tready (axis_tready),
        .axis_tdata  (axis_tdata),
        .may_pop     (may_pop),
        .pop         (pop),
        .data        (data),
        .data_valid  (data_valid),
        .underflow   (underflow),
        .count       (count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_WIDTH-1:0] sb[$];
    int   m_count     = 0;
    int   max_count   = 0;
    bit   m_tready    = 1'b0;
    bit   m_may_pop   = 1'b0;
    bit   m_dv        = 1'b0;
    bit   m_underflow = 1'b0;
    bit   last_acc    = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: predict the edge from current inputs, advance, then compare.
    task automatic tick();
        bit acc;
        bit dp;
        acc = axis_tvalid && m_tready && !rst;
        dp  = pop && m_may_pop && !rst;
        if (acc) sb.push_back(axis_tdata);
        last_acc = acc;
        @(posedge clk);
        #1;
        if (rst) begin
            sb.delete();
            m_count     = 0;
            m_tready    = 1'b0;
            m_may_pop   = 1'b0;
            m_dv        = 1'b0;
            m_underflow = 1'b0;
        end else begin
            m_underflow = m_underflow | (pop && !m_may_pop);
            m_count     = m_count + int'(acc) - int'(dp);
            m_tready    = (m_count < DEPTH);
            m_may_pop   = (m_count != 0);
            m_dv        = dp;
        end
        if (m_count > max_count) max_count = m_count;
        check("tready", axis_tready, m_tready);
        check("may_pop", may_pop, m_may_pop);
        check("count", count, m_count);
        check("data_valid", data_valid, m_dv);
        check("underflow", underflow, m_underflow);
        if (data_valid === 1'b1) begin
            if (sb.size() == 0) check("sb_has_entry", 0, 1);
            else                check("data", data, sb.pop_front());
        end
    endtask

    task automatic push_one(input logic [DATA_WIDTH-1:0] v);
        axis_tvalid = 1'b1;
        axis_tdata  = v;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (last_acc) break;
        end
        check("push_accepted", last_acc, 1);
        axis_tvalid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && (may_pop || data_valid); k++) begin
            pop = may_pop;
            tick();
        end
        pop = 1'b0;
        check("drain_sb_empty", sb.size(), 0);
    endtask

    initial begin
        // Reset then idle
        rst = 1'b1;
        repeat (20) tick();
        check("tready_in_reset", axis_tready, 0);
        rst = 1'b0;
        tick();
        check("idle_tready", axis_tready, 1);
        check("idle_may_pop", may_pop, 0);
        check("idle_count", count, 0);
        check("idle_underflow", underflow, 0);
        check("idle_data", data, 0);

        // Single beat
        push_one(32'd5);
        check("single_may_pop", may_pop, 1);
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check("single_dv", data_valid, 1);
        check("single_data", data, 5);
        check("single_may_pop_after", may_pop, 0);
        check("single_count_after", count, 0);

        // Fill to full, hold a 17th beat, then drain in order
        for (int i = 0; i < DEPTH; i++) push_one(32'(i * 10 + 5));
        axis_tvalid = 1'b1;
        axis_tdata  = 32'd165;
        repeat (3) tick();
        check("full_count", count, DEPTH);
        check("full_tready", axis_tready, 0);
        check("full_no_accept", last_acc, 0);
        for (int i = 0; i < DEPTH; i++) begin
            pop = may_pop;
            tick();
            if (last_acc) axis_tvalid = 1'b0;
        end
        axis_tvalid = 1'b0;
        drain();

        // Concurrent random streaming
        begin
            int i;
            int cyc;
            i   = 0;
            cyc = 0;
            while (i < 200 && cyc < 5000) begin
                if (!axis_tvalid) axis_tvalid = ($urandom_range(0, 1) == 1);
                axis_tdata = 32'(i * 10 + 5);
                pop = ($urandom_range(0, 1) == 1) && may_pop;
                tick();
                cyc++;
                if (last_acc) begin
                    i++;
                    axis_tvalid = 1'b0;
                end
            end
            axis_tvalid = 1'b0;
            check("stream_all_sent", i, 200);
            drain();
            check("stream_max_le_depth", max_count <= DEPTH, 1);
        end

        // Simultaneous push/pop at count=1
        push_one(32'd77);
        axis_tvalid = 1'b1;
        axis_tdata  = 32'd88;
        pop = 1'b1;
        tick();
        axis_tvalid = 1'b0;
        pop = 1'b0;
        check("simul1_count", count, 1);
        check("simul1_may_pop", may_pop, 1);
        check("simul1_data", data, 77);
        drain();

        // Simultaneous push/pop at count=15
        for (int k = 0; k < DEPTH - 1; k++) push_one(32'(1000 + k));
        axis_tvalid = 1'b1;
        axis_tdata  = 32'd2000;
        pop = 1'b1;
        tick();
        axis_tvalid = 1'b0;
        pop = 1'b0;
        check("simul15_count", count, DEPTH - 1);
        check("simul15_tready", axis_tready, 1);
        check("simul15_data", data, 1000);
        drain();

        // Underflow is sticky across traffic
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check("uflow_set", underflow, 1);
        check("uflow_no_dv", data_valid, 0);
        for (int k = 0; k < 3; k++) push_one(32'(300 + k));
        drain();
        check("uflow_sticky", underflow, 1);

        // Reset with count=7 discards contents and clears underflow
        for (int k = 0; k < 7; k++) push_one(32'(500 + k));
        check("pre_reset_count", count, 7);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("post_reset_count", count, 0);
        check("post_reset_may_pop", may_pop, 0);
        check("post_reset_uflow", underflow, 0);
        push_one(32'd999);
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check("post_reset_data", data, 999);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
